// File: rtl/debug_uart_tx.sv
// debug_uart_tx
//   Captures the CPU debug outputs on request and sends them as one 10-byte
//   packet over a UART 8N1 line (LSB first, no gap between bytes):
//     SYNC_BYTE, p1..p7, {7'b0, led}, checksum
//   The checksum is the mod-256 sum of p1..p7 and {7'b0, led}.
//
// Ports
//   clk                      system clock, rising edge
//   reset                    synchronous, active-high reset
//   start                    request a snapshot + packet (ignored while busy)
//   debug_port1..debug_port7 CPU debug bytes
//   led                      CPU led output
//   tx                       UART serial line, idle high (registered)
//   busy                     high while a packet is in flight (registered)
//   done                     one-cycle pulse when a packet completes (registered)

module debug_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] debug_port1,
    input  logic [7:0] debug_port2,
    input  logic [7:0] debug_port3,
    input  logic [7:0] debug_port4,
    input  logic [7:0] debug_port5,
    input  logic [7:0] debug_port6,
    input  logic [7:0] debug_port7,
    input  logic       led,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LAST_BYTE = 4'd9;

    logic [1:0]  state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [3:0]  byte_idx;
    logic [7:0]  shift_reg;

    logic [7:0]  snap [8];
    logic [7:0]  checksum;

    logic        accept;
    logic        bit_end;
    logic [3:0]  next_idx;
    logic [7:0]  next_byte;
    logic [10:0] sum_in;

    assign accept   = start && !busy;
    assign bit_end  = (bit_cnt == BIT_LAST);
    assign next_idx = byte_idx + 4'd1;

    // Checksum of the live inputs, latched together with the snapshot so the
    // last byte never depends on inputs that changed after accept.
    always_comb begin
        // NOTE: every variable written here gets a value before any
        // conditional logic, so no path leaves it unassigned (no latch).
        sum_in = {10'd0, led};
        sum_in = sum_in + {3'd0, debug_port1};
        sum_in = sum_in + {3'd0, debug_port2};
        sum_in = sum_in + {3'd0, debug_port3};
        sum_in = sum_in + {3'd0, debug_port4};
        sum_in = sum_in + {3'd0, debug_port5};
        sum_in = sum_in + {3'd0, debug_port6};
        sum_in = sum_in + {3'd0, debug_port7};
    end

    // Byte loaded into the shift register on a STOP -> START transition:
    // indices 1..8 come from the snapshot, index 9 is the checksum.
    always_comb begin
        next_byte = checksum;
        for (int i = 0; i < 8; i++) begin
            if (next_idx == 4'(i + 1)) next_byte = snap[i];
        end
    end

    // NOTE: the snapshot is plain data storage, qualified by accept before it
    // is ever read, so it is deliberately left without a reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            snap[0]  <= debug_port1;
            snap[1]  <= debug_port2;
            snap[2]  <= debug_port3;
            snap[3]  <= debug_port4;
            snap[4]  <= debug_port5;
            snap[5]  <= debug_port6;
            snap[6]  <= debug_port7;
            snap[7]  <= {7'd0, led};
            checksum <= 8'(sum_in);
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every flop
    // sees the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_cnt   <= 16'd0;
            bit_idx   <= 3'd0;
            byte_idx  <= 4'd0;
            shift_reg <= 8'd0;
        end else begin
            done <= 1'b0;
            if (state != IDLE) begin
                bit_cnt <= bit_end ? 16'd0 : bit_cnt + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= START;
                        busy      <= 1'b1;
                        tx        <= 1'b0;
                        bit_cnt   <= 16'd0;
                        byte_idx  <= 4'd0;
                        shift_reg <= SYNC_BYTE;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state     <= DATA;
                        bit_idx   <= 3'd0;
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            bit_idx <= 3'd0;
                            tx      <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (byte_idx == LAST_BYTE) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            byte_idx <= 4'd0;
                        end else begin
                            // Next start bit follows the stop bit directly.
                            state     <= START;
                            tx        <= 1'b0;
                            byte_idx  <= next_idx;
                            shift_reg <= next_byte;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/debug_uart_tx.md
Name: debug_uart_tx

Overview:
- Snapshots the CPU debug outputs (debug_port1..debug_port7 and led) on request.
- Sends the snapshot as a fixed 10-byte framed packet over a UART 8N1 serial line.
- It is the transmit end of the board's debug-observation path: the host-side receiver decodes what the bench currently reads directly from the CPU ports.
- Sits beside cpu at the top level; its inputs connect straight to the cpu debug outputs.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535
SYNC_BYTE, 8'hA5, first byte of every packet

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a snapshot + packet; sampled only when busy=0
debug_port1..debug_port7  input  8 each  CPU debug bytes
led  input  1  CPU led output
tx  output  1  UART serial line, idle high
busy  output  1  high while a packet is in flight
done  output  1  one-cycle pulse when a packet completes

Behaviour:
- Reset values (all outputs registered): tx=1, busy=0, done=0, state=IDLE, all counters 0.
- Reset asserted mid-packet: at the next edge the block returns to those values; the partial frame is abandoned; no done pulse.
- Packet format, transmitted in this order (10 bytes): SYNC_BYTE, p1, p2, p3, p4, p5, p6, p7, {7'b0, led}, checksum.
- Checksum = (p1+...+p7+{7'b0,led}) mod 256. SYNC_BYTE is excluded. Compute it with 11-bit accumulation, then truncate.
- Accept: edge at which start=1 and busy=0.
  - The snapshot registers capture all eight input bytes at that edge.
  - busy goes 1 at that edge.
  - The state moves to START, with tx=0 from the same edge.
  - Input changes after the accept edge do not affect the packet.
- start while busy=1 is ignored: not queued, no effect.
- Byte framing, LSB first:
  - 1 start bit (0), then 8 data bits, then 1 stop bit (1).
  - Each bit holds for exactly CLKS_PER_BIT cycles.
  - There is no idle gap between bytes; the next start bit follows the stop bit immediately.
- State machine:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if byte_idx<9, incrementing byte_idx.
  - STOP -> IDLE if byte_idx==9.
- Counters:
  - bit-cycle counter, 16 bits, wraps to 0 at CLKS_PER_BIT-1;
  - bit_idx, 0..7;
  - byte_idx, 0..9, used to mux snapshot/sync/checksum into the shift register at each START entry.
- Latency: accept at edge E; the frame occupies edges E .. E+100*CLKS_PER_BIT-1. At edge E+100*CLKS_PER_BIT:
  - busy=0 and tx=1;
  - done=1 for exactly one cycle.
- start=1 in the cycle where done=1 is accepted (busy is already 0), so back-to-back packets are separated only by that one idle cycle.
- tx is driven from a flop. It never glitches, and stays high in IDLE.

Test Plan:
1. CLKS_PER_BIT=4; ports=01..07, led=1; pulse start.
   - Bench UART decoder reads A5 01 02 03 04 05 06 07 01 1D.
   - busy is high for exactly 400 cycles, followed by one done pulse.
2. Checksum wrap: all ports FF, led=1.
   - Decoded checksum byte is FA (1786 mod 256).
   - Byte 8 is 01.
3. Snapshot isolation: change every port to 00 one cycle after accept.
   - The packet still carries the original values and checksum.
4. start pulsed at cycles 50 and 200 of an active packet.
   - Both pulses are ignored: exactly one packet, one done pulse, busy low after 400 cycles.
5. Reset at cycle 123 of a packet.
   - Next edge: tx=1, busy=0, done=0.
   - No further bits are sent.
   - A new start afterwards produces a full, correct packet starting with A5.
6. Back-to-back: start held high continuously.
   - Packets repeat with exactly one idle-high cycle (the done cycle) between the last stop bit and the next start bit.
   - Each packet's bytes reflect the ports at its own accept edge.
